// File: rtl/sumador_bcd_pkg.sv
// rtl/sumador_bcd_pkg.sv - shared states, widths and double-dabble helper for the BCD adder
package sumador_bcd_pkg;

    localparam int BCD_W       = 4;
    localparam int SUM_W       = 11;
    localparam int BIN_W       = 10;
    localparam int SHIFT_STEPS = 11;
    localparam int STEP_W      = 4;
    localparam int BCD_FIELD_W = 4 * BCD_W;
    localparam int DD_W        = BCD_FIELD_W + SUM_W;

    localparam logic [BCD_W-1:0]  BCD_MAX   = 4'd9;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SHIFT_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Double-dabble correction: any nibble that would reach 10+ after the
    // next left shift gets 3 added now so the shift carries into the next digit.
    function automatic logic [BCD_FIELD_W-1:0] dabble_adjust(input logic [BCD_FIELD_W-1:0] bcd);
        logic [BCD_FIELD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*BCD_W +: BCD_W] >= 4'd5) begin
                res[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd3_a_bin.sv
// rtl/bcd3_a_bin.sv - three BCD digits to 10-bit binary with invalid-digit flag
module bcd3_a_bin
    import sumador_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d3,
    input  logic [BCD_W-1:0] d2,
    input  logic [BCD_W-1:0] d1,
    output logic [BIN_W-1:0] bin,
    output logic             bad
);

    // Weighted sum of the digits; value is meaningless when bad is set
    always_comb begin
        bin = ({6'd0, d3} * 10'd100) + ({6'd0, d2} * 10'd10) + {6'd0, d1};
        bad = (d3 > BCD_MAX) || (d2 > BCD_MAX) || (d1 > BCD_MAX);
    end

endmodule

// File: rtl/sumador_bcd.sv
// rtl/sumador_bcd.sv - three-digit BCD adder using binary add and double-dabble conversion
module sumador_bcd
    import sumador_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] dig1_3,
    input  logic [BCD_W-1:0] dig1_2,
    input  logic [BCD_W-1:0] dig1_1,
    input  logic [BCD_W-1:0] dig2_3,
    input  logic [BCD_W-1:0] dig2_2,
    input  logic [BCD_W-1:0] dig2_1,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BCD_W-1:0] sum_d3,
    output logic [BCD_W-1:0] sum_d2,
    output logic [BCD_W-1:0] sum_d1,
    output logic [BCD_W-1:0] sum_d0
);

    state_t                 state;
    logic [BCD_W-1:0]       a3_q, a2_q, a1_q;
    logic [BCD_W-1:0]       b3_q, b2_q, b1_q;
    logic [BCD_FIELD_W-1:0] bcd_q;
    logic [SUM_W-1:0]       bin_q;
    logic [STEP_W-1:0]      step_q;

    logic [BIN_W-1:0]       a_bin, b_bin;
    logic                   a_bad, b_bad;
    logic [DD_W-1:0]        dd_next;

    // Converters look only at the captured digits, so live inputs cannot disturb an operation
    bcd3_a_bin u_conv_a (
        .d3  (a3_q),
        .d2  (a2_q),
        .d1  (a1_q),
        .bin (a_bin),
        .bad (a_bad)
    );

    bcd3_a_bin u_conv_b (
        .d3  (b3_q),
        .d2  (b2_q),
        .d1  (b1_q),
        .bin (b_bin),
        .bad (b_bad)
    );

    // One double-dabble step: correct nibbles, then shift the combined register left
    always_comb begin
        dd_next = {dabble_adjust(bcd_q), bin_q} << 1;
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            sum_d3 <= '0;
            sum_d2 <= '0;
            sum_d1 <= '0;
            sum_d0 <= '0;
            a3_q   <= '0;
            a2_q   <= '0;
            a1_q   <= '0;
            b3_q   <= '0;
            b2_q   <= '0;
            b1_q   <= '0;
            bcd_q  <= '0;
            bin_q  <= '0;
            step_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a3_q  <= dig1_3;
                        a2_q  <= dig1_2;
                        a1_q  <= dig1_1;
                        b3_q  <= dig2_3;
                        b2_q  <= dig2_2;
                        b1_q  <= dig2_1;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (a_bad || b_bad) begin
                        sum_d3 <= '0;
                        sum_d2 <= '0;
                        sum_d1 <= '0;
                        sum_d0 <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        bin_q  <= {1'b0, a_bin} + {1'b0, b_bin};
                        bcd_q  <= '0;
                        step_q <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q  <= dd_next[DD_W-1:SUM_W];
                    bin_q  <= dd_next[SUM_W-1:0];
                    step_q <= step_q + 4'd1;
                    if (step_q == LAST_STEP) begin
                        sum_d3 <= dd_next[DD_W-1          -: BCD_W];
                        sum_d2 <= dd_next[DD_W-1-BCD_W    -: BCD_W];
                        sum_d1 <= dd_next[DD_W-1-2*BCD_W  -: BCD_W];
                        sum_d0 <= dd_next[DD_W-1-3*BCD_W  -: BCD_W];
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        step_q <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_bcd.sv
// tb/tb_sumador_bcd.sv - randomized self-checking bench for sumador_bcd
module tb_sumador_bcd;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dig1_3, dig1_2, dig1_1;
    logic [3:0] dig2_3, dig2_2, dig2_1;
    logic       busy, done, err;
    logic [3:0] sum_d3, sum_d2, sum_d1, sum_d0;

    int vectors;
    int miscompares;

    sumador_bcd dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dig1_3 (dig1_3),
        .dig1_2 (dig1_2),
        .dig1_1 (dig1_1),
        .dig2_3 (dig2_3),
        .dig2_2 (dig2_2),
        .dig2_1 (dig2_1),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .sum_d3 (sum_d3),
        .sum_d2 (sum_d2),
        .sum_d1 (sum_d1),
        .sum_d0 (sum_d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rand_digit();
        return 4'($urandom_range(0, 9));
    endfunction

    // Apply one operation from the current point (just after an edge) and check it.
    // noise: pulse start and scramble the digit inputs mid-operation.
    // b2b: leave the bench in the done cycle so the next call starts back-to-back.
    task automatic run_op(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                          input logic [3:0] b3, input logic [3:0] b2, input logic [3:0] b1,
                          input bit noise, input bit b2b);
        int  av, bv, s, n, busy_cnt, exp_lat;
        bit  bad, got;
        int  e3, e2, e1, e0;
        bad = (a3 > 9) || (a2 > 9) || (a1 > 9) || (b3 > 9) || (b2 > 9) || (b1 > 9);
        av  = int'(a3) * 100 + int'(a2) * 10 + int'(a1);
        bv  = int'(b3) * 100 + int'(b2) * 10 + int'(b1);
        s   = av + bv;
        e3  = bad ? 0 : s / 1000;
        e2  = bad ? 0 : (s / 100) % 10;
        e1  = bad ? 0 : (s / 10) % 10;
        e0  = bad ? 0 : s % 10;
        exp_lat = bad ? 1 : 12;

        dig1_3 = a3; dig1_2 = a2; dig1_1 = a1;
        dig2_3 = b3; dig2_2 = b2; dig2_1 = b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_cnt = int'(busy);
        n        = 0;
        got      = 1'b0;
        while (!got && n < 30) begin
            if (noise && n == 4) begin
                start  = 1'b1;
                dig1_3 = rand_digit(); dig1_2 = rand_digit(); dig1_1 = rand_digit();
                dig2_3 = rand_digit(); dig2_2 = rand_digit(); dig2_1 = rand_digit();
            end else if (noise && n == 5) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
            else busy_cnt += int'(busy);
        end
        check_val("latency", got ? n : -1, exp_lat);
        check_val("busy_cycles", busy_cnt, exp_lat);
        check_val("busy_at_done", int'(busy), 0);
        check_val("err", int'(err), bad ? 1 : 0);
        check_val("sum_d3", int'(sum_d3), e3);
        check_val("sum_d2", int'(sum_d2), e2);
        check_val("sum_d1", int'(sum_d1), e1);
        check_val("sum_d0", int'(sum_d0), e0);
        if (!b2b) begin
            @(posedge clk); #1;
            check_val("done_one_cycle", int'(done), 0);
            check_val("sum_hold", int'({sum_d3, sum_d2, sum_d1, sum_d0}),
                      (e3 << 12) | (e2 << 8) | (e1 << 4) | e0);
        end
    endtask

    initial begin
        int done_seen;
        logic [3:0] d [6];
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start  = 1'b1;
        dig1_3 = 4'd1; dig1_2 = 4'd2; dig1_1 = 4'd3;
        dig2_3 = 4'd4; dig2_2 = 4'd5; dig2_1 = 4'd6;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_sum", int'({sum_d3, sum_d2, sum_d1, sum_d0}), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;

        run_op(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
        run_op(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
        run_op(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        run_op(4'd1, 4'd2, 4'd3, 4'd4, 4'hA, 4'd6, 1'b0, 1'b0);
        run_op(4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        run_op(4'd7, 4'd3, 4'd8, 4'd6, 4'd4, 4'd9, 1'b1, 1'b0);

        // Reset in the middle of an operation aborts it without a done pulse
        dig1_3 = 4'd8; dig1_2 = 4'd7; dig1_1 = 4'd6;
        dig2_3 = 4'd5; dig2_2 = 4'd4; dig2_1 = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_done", int'(done), 0);
        check_val("abort_sum", int'({sum_d3, sum_d2, sum_d1, sum_d0}), 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            done_seen += int'(done);
        end
        check_val("abort_no_done", done_seen, 0);
        run_op(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);

        // Back-to-back: start held in the done cycle
        run_op(4'd2, 4'd4, 4'd6, 4'd3, 4'd5, 4'd7, 1'b0, 1'b1);
        run_op(4'd0, 4'd9, 4'd9, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
        run_op(4'd9, 4'd0, 4'd0, 4'd1, 4'hF, 4'd0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 6; j++) d[j] = rand_digit();
            if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 5)] = 4'($urandom_range(10, 15));
            run_op(d[0], d[1], d[2], d[3], d[4], d[5],
                   ($urandom_range(0, 4) == 0), (k != 39) && ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sumador_bcd.md
SUMADOR_BCD -- requirements
Module: sumador_bcd

Interface
REQ-001 The module SHALL have no parameters; all timing constants SHALL come from the shared package.
REQ-002 The module SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The module SHALL have port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have port start  input  1  one-cycle request to add the present operand digits.
REQ-005 The module SHALL have ports dig1_3, dig1_2, dig1_1  input  4 each  operand A hundreds, tens and units (BCD).
REQ-006 The module SHALL have ports dig2_3, dig2_2, dig2_1  input  4 each  operand B hundreds, tens and units (BCD).
REQ-007 The module SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 The module SHALL have port done  output  1  one-cycle pulse marking that the result outputs have updated.
REQ-009 The module SHALL have port err  output  1  high when the last accepted operand set contained a digit greater than 9.
REQ-010 The module SHALL have ports sum_d3, sum_d2, sum_d1, sum_d0  output  4 each  result thousands, hundreds, tens and units (BCD).

Function
REQ-011 The FSM SHALL have exactly these states: IDLE, ADD, SHIFT.
REQ-012 In IDLE, start=1 at edge k SHALL capture all six digits into internal registers and move the FSM to ADD; start SHALL be ignored in every other state.
REQ-013 In ADD, operand bits SHALL be computed as A = 100*d3 + 10*d2 + d1 and B likewise, each 10 bits wide.
REQ-014 In ADD at edge k+1, the sum A+B SHALL be loaded 11 bits wide (range 0..1998) into the double-dabble shift register, the BCD field SHALL be cleared, the step counter SHALL be set to 0, and the FSM SHALL move to SHIFT.
REQ-015 In ADD, if any captured digit is greater than 9, then at edge k+1 the FSM SHALL instead set sum_d3..sum_d0 to 0, set err=1, pulse done, and return to IDLE.
REQ-016 In SHIFT, each edge SHALL first add 3 to every BCD nibble that is >= 5 and then shift the {BCD, binary} register left by 1.
REQ-017 SHIFT SHALL perform exactly 11 steps, on edges k+2 through k+12.
REQ-018 On the 11th step (edge k+12), the FSM SHALL register the four BCD nibbles onto sum_d3..sum_d0, clear err, pulse done for one cycle, and return to IDLE.
REQ-019 Valid-path latency SHALL be 12 cycles from the start edge to the done edge, with busy high for exactly those 12 cycles.
REQ-020 Error-path latency SHALL be 1 cycle.
REQ-021 sum_d3..sum_d0 and err SHALL hold their values between done pulses; changes on the digit inputs after capture SHALL have no effect.
REQ-022 start asserted in the same cycle that done is high SHALL be accepted, because the FSM is in IDLE, allowing back-to-back operations.
REQ-023 sum_d3 SHALL be either 0 or 1 for every valid input.

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, done=0, err=0, sum_d3..sum_d0=0, step counter=0, and capture registers=0, overriding start in the same cycle.
REQ-025 rst asserted during ADD or SHIFT SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, ADD, SHIFT), SHIFT_STEPS=11, BCD_MAX=9, SUM_W=11, and BCD_W=4.
REQ-027 One combinational sub-module, bcd3_a_bin, SHALL convert three BCD digits to a 10-bit binary value and flag any digit > BCD_MAX; it SHALL be instantiated twice.
REQ-028 All other logic SHALL reside in sumador_bcd; the total RTL SHALL be roughly 150-250 lines.

Verification
REQ-029 Scenario: A=1,2,3 and B=4,5,6 with start at edge k -> done at edge k+12, sum=0,5,7,9, err=0, busy high for 12 cycles.
REQ-030 Scenario: A=9,9,9 and B=9,9,9 -> sum=1,9,9,8; A=0,0,0 and B=0,0,0 -> sum=0,0,0,0.
REQ-031 Scenario: dig2_2=4'hA with start -> done at edge k+1, err=1, sum=0,0,0,0; a following valid start (5,0,0 + 5,0,0) -> sum=1,0,0,0 and err=0.
REQ-032 Scenario: start pulsed again at edge k+5 and the digit inputs changed mid-operation -> still exactly one done at edge k+12 with the originally captured result.
REQ-033 Scenario: rst at edge k+6 -> all outputs 0, no done pulse; the next start (0,0,1 + 0,0,1) -> sum=0,0,0,2 after 12 cycles.
REQ-034 Scenario: start held high in the done cycle -> a second operation begins immediately and its done follows 12 cycles later.
